// File: rtl/mat_vect_conv_chk.sv
// -----------------------------------------------------------------------------
// mat_vect_conv_chk
//
// Streaming convergence checker for the iterative solver's error vectors.
// Each run consumes vectors of VEC_LEN IEEE-754 single error elements. Every
// element is tested with a strict |e| < |tol| comparison on the 31 magnitude
// bits. Convergence is declared after PASS_COUNT consecutive passing vectors.
// A timeout is declared once max_iter vectors have been evaluated
// (max_iter = 0 means unlimited).
//
// Optional feature macro: MAT_VECT_CONV_MAXERR_EN
//   defined     : max_err reports the largest |e| of the last evaluated vector
//   not defined : max_err is tied to 0 and no running-max logic is built
//
// Ports
//   ap_clk, ap_rst  clock (rising edge) / asynchronous active-high reset
//   start           begin a run (only honoured in IDLE); latches tol, max_iter
//   tol             tolerance (sign bit ignored)
//   max_iter        iteration limit, 0 = unlimited
//   err_valid       error element valid
//   err_data        error element
//   err_ready       element accepted when err_valid & err_ready (state RUN)
//   busy            high in every state except IDLE
//   done            one-cycle pulse at run end
//   converged       run ended by convergence (held until next start)
//   timeout         run ended by iteration limit (held until next start)
//   iter_count      vectors evaluated in the current / last run (saturating)
//   max_err         largest |e| in the last evaluated vector
// -----------------------------------------------------------------------------
module mat_vect_conv_chk #(
  parameter int DATA_WIDTH = 32,
  parameter int VEC_LEN    = 8,
  parameter int ITER_WIDTH = 16,
  parameter int PASS_COUNT = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tol,
  input  logic [ITER_WIDTH-1:0] max_iter,
  input  logic                  err_valid,
  input  logic [DATA_WIDTH-1:0] err_data,
  output logic                  err_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  converged,
  output logic                  timeout,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic [DATA_WIDTH-1:0] max_err
);

  localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int STRK_W = $clog2(PASS_COUNT + 1);
  // Clears the sign bit so that -x and +x (including -0/+0) share one magnitude.
  localparam logic [DATA_WIDTH-1:0] MAG_MASK = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, EVAL, DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] tol_abs;
  logic [ITER_WIDTH-1:0] max_iter_r;
  logic [STRK_W-1:0]     streak;
  logic [CNT_W-1:0]      elem_cnt;
  logic                  vec_pass;

  logic                  hs;
  logic                  last_elem;
  logic [DATA_WIDTH-1:0] err_abs;
  logic                  elem_pass;
  logic [ITER_WIDTH-1:0] iter_nxt;
  logic [STRK_W-1:0]     streak_nxt;
  logic                  conv_now;
  logic                  tmo_now;

  // Iteration count holds at all-ones instead of wrapping.
  function automatic logic [ITER_WIDTH-1:0] sat_inc(input logic [ITER_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mag_max(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign err_ready = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    hs         = err_valid && (state == RUN);
    last_elem  = (elem_cnt == CNT_W'(VEC_LEN - 1));
    err_abs    = err_data & MAG_MASK;
    // NaN/Inf magnitudes sit above every finite magnitude, so they fail here.
    elem_pass  = (err_abs < tol_abs);
    iter_nxt   = sat_inc(iter_count);
    streak_nxt = streak + 1'b1;
    conv_now   = vec_pass && (streak_nxt == STRK_W'(PASS_COUNT));
    // Convergence takes priority when both happen in the same evaluation.
    tmo_now    = !conv_now && (max_iter_r != '0) && (iter_nxt == max_iter_r);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (hs && last_elem) state_nxt = EVAL;
      EVAL: state_nxt = (conv_now || tmo_now) ? DONE : RUN;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Element accumulation (RUN) and vector evaluation (EVAL)
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      tol_abs    <= '0;
      max_iter_r <= '0;
      iter_count <= '0;
      streak     <= '0;
      elem_cnt   <= '0;
      vec_pass   <= 1'b0;
      converged  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            tol_abs    <= tol & MAG_MASK;
            max_iter_r <= max_iter;
            iter_count <= '0;
            streak     <= '0;
            elem_cnt   <= '0;
            vec_pass   <= 1'b1;
            converged  <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        RUN: begin
          if (hs) begin
            vec_pass <= vec_pass & elem_pass;
            elem_cnt <= last_elem ? '0 : elem_cnt + 1'b1;
          end
        end
        EVAL: begin
          iter_count <= iter_nxt;
          streak     <= vec_pass ? streak_nxt : '0;
          converged  <= conv_now;
          timeout    <= tmo_now;
          vec_pass   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MAT_VECT_CONV_MAXERR_EN
  logic [DATA_WIDTH-1:0] run_max;

  // The first element of each vector restarts the running maximum.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      run_max <= '0;
      max_err <= '0;
    end else begin
      if (state == IDLE && start) begin
        run_max <= '0;
        max_err <= '0;
      end
      if (hs) run_max <= (elem_cnt == '0) ? err_abs : mag_max(run_max, err_abs);
      if (state == EVAL) max_err <= run_max;
    end
  end
`else
  assign max_err = '0;
`endif

endmodule

// File: tb/tb_mat_vect_conv_chk.sv
module tb_mat_vect_conv_chk;

  localparam int VL = 4;
  localparam logic [31:0] TOL = 32'h3A83126F;
`ifdef MAT_VECT_CONV_MAXERR_EN
  localparam bit MAXERR_EN = 1'b1;
`else
  localparam bit MAXERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        ap_rst;
  logic        start;
  logic [31:0] tol;
  logic [15:0] max_iter;
  logic        err_valid;
  logic [31:0] err_data;
  logic        err_ready, busy, done, converged, timeout;
  logic [15:0] iter_count;
  logic [31:0] max_err;

  mat_vect_conv_chk #(
    .DATA_WIDTH(32), .VEC_LEN(VL), .ITER_WIDTH(16), .PASS_COUNT(2)
  ) dut (
    .ap_clk(clk), .ap_rst(ap_rst), .start(start), .tol(tol), .max_iter(max_iter),
    .err_valid(err_valid), .err_data(err_data), .err_ready(err_ready),
    .busy(busy), .done(done), .converged(converged), .timeout(timeout),
    .iter_count(iter_count), .max_err(max_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        conv;
    logic        tmo;
    logic [15:0] iter;
    logic [31:0] merr;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] pk(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] me(input logic [31:0] v);
    return MAXERR_EN ? v : 32'h0;
  endfunction

  // Scoreboard monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("converged",  {31'd0, converged}, {31'd0, e.conv});
        chk("timeout",    {31'd0, timeout},   {31'd0, e.tmo});
        chk("iter_count", {16'd0, iter_count}, {16'd0, e.iter});
        chk("max_err",    max_err, e.merr);
      end
    end
  end

  task automatic push(input logic c, input logic t, input logic [15:0] it, input logic [31:0] m);
    exp_t e;
    e.conv = c; e.tmo = t; e.iter = it; e.merr = me(m);
    q.push_back(e);
  endtask

  // All stimulus tasks start and end at a falling edge.
  task automatic do_start(input logic [31:0] t, input logic [15:0] m);
    tol = t; max_iter = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start",  {31'd0, busy},      32'd1);
    chk("ready_after_start", {31'd0, err_ready}, 32'd1);
  endtask

  task automatic send_elem(input logic [31:0] d);
    int n;
    err_valid = 1'b1; err_data = d;
    n = 0;
    while (!err_ready && n < 50) begin @(negedge clk); n++; end
    if (!err_ready) chk("ready_wait", 32'd0, 32'd1);
    @(negedge clk);
    err_valid = 1'b0;
  endtask

  task automatic send_vec(input logic [127:0] v, input bit gaps, input bit more);
    for (int i = 0; i < VL; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) @(negedge clk);
      send_elem(v[32*i +: 32]);
    end
    chk("bubble_ready_low", {31'd0, err_ready}, 32'd0);
    if (more) begin
      @(negedge clk);
      chk("ready_rearm", {31'd0, err_ready}, 32'd1);
    end
  endtask

  task automatic wait_idle(input logic exp_conv, input logic exp_tmo);
    int n;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    chk("run_end_bound", {31'd0, busy}, 32'd0);
    chk("conv_hold", {31'd0, converged}, {31'd0, exp_conv});
    chk("tmo_hold",  {31'd0, timeout},   {31'd0, exp_tmo});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_err_ready"},  {31'd0, err_ready}, 32'd0);
    chk({tag, "_busy"},       {31'd0, busy},      32'd0);
    chk({tag, "_done"},       {31'd0, done},      32'd0);
    chk({tag, "_converged"},  {31'd0, converged}, 32'd0);
    chk({tag, "_timeout"},    {31'd0, timeout},   32'd0);
    chk({tag, "_iter_count"}, {16'd0, iter_count}, 32'd0);
    chk({tag, "_max_err"},    max_err, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pass_v, fail_v, neg_v, eqtol_v, nan_v, negz_v, mx_v;
    pass_v  = pk(32'h3A000000, 32'h3A000000, 32'h3A000000, 32'h3A000000);
    fail_v  = pk(32'h3A000000, 32'h3B000000, 32'h3A000000, 32'h3A000000);
    neg_v   = pk(32'hBA000000, 32'hBA000000, 32'hBA000000, 32'hBA000000);
    eqtol_v = pk(32'h3A000000, 32'h3A000000, TOL,          32'h3A000000);
    nan_v   = pk(32'h3A000000, 32'hFFC00000, 32'h3A000000, 32'h3A000000);
    negz_v  = pk(32'h3A000000, 32'h80000000, 32'h3A000000, 32'h3A000000);
    mx_v    = pk(32'h3A000000, 32'hBA800000, 32'h39000000, 32'h00000000);

    ap_rst = 1'b1; start = 1'b0; tol = '0; max_iter = '0;
    err_valid = 1'b0; err_data = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    ap_rst = 1'b0;
    @(negedge clk);

    // Two passing vectors converge at iteration 2.
    push(1'b1, 1'b0, 16'd2, 32'h3A000000);
    do_start(TOL, 16'd10);
    send_vec(pass_v, 1'b0, 1'b1);
    send_vec(pass_v, 1'b0, 1'b0);
    wait_idle(1'b1, 1'b0);

    // Streak broken by a failing vector, then negative passing vectors.
    push(1'b1, 1'b0, 16'd4, 32'h3A000000);
    do_start(TOL, 16'd10);
    send_vec(pass_v, 1'b0, 1'b1);
    send_vec(fail_v, 1'b0, 1'b1);
    send_vec(neg_v,  1'b0, 1'b1);
    send_vec(neg_v,  1'b0, 1'b0);
    wait_idle(1'b1, 1'b0);

    // Element equal to tol fails every time: timeout at max_iter.
    push(1'b0, 1'b1, 16'd3, TOL);
    do_start(TOL, 16'd3);
    send_vec(eqtol_v, 1'b0, 1'b1);
    send_vec(eqtol_v, 1'b0, 1'b1);
    send_vec(eqtol_v, 1'b0, 1'b0);
    wait_idle(1'b0, 1'b1);

    // NaN fails; convergence and the limit coincide at iteration 3.
    push(1'b1, 1'b0, 16'd3, 32'h3A000000);
    do_start(TOL, 16'd3);
    send_vec(nan_v,  1'b0, 1'b1);
    send_vec(pass_v, 1'b0, 1'b1);
    send_vec(pass_v, 1'b0, 1'b0);
    wait_idle(1'b1, 1'b0);

    // Gapped stream with a -0 element, unlimited iterations.
    push(1'b1, 1'b0, 16'd2, 32'h3A000000);
    do_start(TOL, 16'd0);
    send_vec(negz_v, 1'b1, 1'b1);
    send_vec(negz_v, 1'b1, 1'b0);
    wait_idle(1'b1, 1'b0);

    // Reset after 2 of 4 elements discards the partial vector.
    do_start(TOL, 16'd10);
    send_elem(32'h3B000000);
    send_elem(32'h3B000000);
    #2 ap_rst = 1'b1;
    #1 chk_zero("midreset");
    @(negedge clk);
    ap_rst = 1'b0;
    @(negedge clk);
    push(1'b1, 1'b0, 16'd2, 32'h3A000000);
    do_start(TOL, 16'd10);
    send_vec(pass_v, 1'b0, 1'b1);
    send_vec(pass_v, 1'b0, 1'b0);
    wait_idle(1'b1, 1'b0);

    // Largest magnitude of the last vector.
    push(1'b1, 1'b0, 16'd2, 32'h3A800000);
    do_start(TOL, 16'd10);
    send_vec(mx_v, 1'b0, 1'b1);
    send_vec(mx_v, 1'b0, 1'b0);
    wait_idle(1'b1, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
